stream_averager: RTL
====================

# stream_averager

Block-averaging decimator placed directly downstream of the stream adder. Consumes the adder's signed valid-qualified sample stream, sums non-overlapping blocks of 2^LOG2_N accepted samples and emits one arithmetic mean per block. The result is a decimated, noise-reduced stream at 1/2^LOG2_N of the input sample rate. There is no backpressure; the block must accept a sample on every cycle that valid is high.

## Interface

- DATA_WIDTH, 16: width of input and output samples (signed two's complement).
- LOG2_N, 2: log2 of the block length N. Legal range is 0..8; 0 makes the block a one-cycle register.

- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous reset, active-high.
- data_i_tdata  input  DATA_WIDTH  signed input sample.
- data_i_tvalid  input  1  input sample valid; the sample is accepted on every rising edge where this is high.
- data_o_tdata  output  DATA_WIDTH  signed block mean.
- data_o_tvalid  output  1  one-cycle pulse marking a new mean.

## Operation

- Internal state:
  - Sample counter `cnt`, LOG2_N bits, range 0..N-1.
  - Accumulator `acc`, signed, DATA_WIDTH+LOG2_N bits. These guard bits make overflow impossible for any input sequence.
- Reset (reset=1 at an edge):
  - `cnt`, `acc`, data_o_tdata and data_o_tvalid all become 0.
  - Reset has priority over everything else.
  - A reset mid-block discards the partial sum; the next accepted sample becomes sample 0 of a fresh block.
- Edge with data_i_tvalid=0: `cnt` and `acc` hold, data_o_tdata holds, data_o_tvalid becomes 0.
- Edge with data_i_tvalid=1 and `cnt` < N-1:
  - `acc` <= `acc` + sign-extended sample.
  - `cnt` <= `cnt`+1.
  - data_o_tvalid <= 0.
- Edge with data_i_tvalid=1 and `cnt` = N-1 (block complete):
  - data_o_tdata <= (`acc` + sign-extended sample) >>> LOG2_N. This is an arithmetic shift, i.e. truncation toward minus infinity, and the low DATA_WIDTH bits are taken. The result always fits: min ≤ mean ≤ max of the inputs.
  - data_o_tvalid <= 1.
  - `acc` <= 0 and `cnt` <= 0 in the same edge. The next sample starts a new block with no lost cycle.
- LOG2_N=0: every accepted sample completes a block. data_o_tdata = input delayed one cycle, and data_o_tvalid = data_i_tvalid delayed one cycle.
- data_o_tdata holds its last mean between pulses. Downstream must qualify it with data_o_tvalid.
- Gaps in data_i_tvalid of any length are allowed. The block boundary is defined by the count of accepted samples only, never by time.

## Timing

- Latency: the mean appears, with data_o_tvalid=1, in the cycle immediately after the edge that accepted the Nth sample of the block.
- data_o_tvalid is high for exactly one cycle per block and is never high on two consecutive cycles when LOG2_N ≥ 1.
- Sustained throughput with continuous valid: one input per cycle, one output every N cycles, and output pulses exactly N cycles apart.
- The first pulse after reset deassertion comes no earlier than N cycles after the first accepted sample.
- Reset asserted in the same cycle as a completing sample: reset wins, no pulse is produced, and all outputs are 0 on the next cycle.

## Test plan

- Continuous valid: reset, then samples 1,2,3,4 on consecutive cycles (DATA_WIDTH=16, LOG2_N=2) -> data_o_tdata=2, with data_o_tvalid high for one cycle, one cycle after sample 4.
- Negative truncation: samples -1,-1,-1,-2 -> sum -5, data_o_tdata=-2 (0xFFFE), not -1.
- Extremes: 4×32767 -> 32767; then 4×-32768 -> -32768; no wrap, two pulses 4 cycles apart.
- Gapped input: 4,4,4,4 separated by 3 idle cycles each -> a single pulse with value 4 one cycle after the 4th accepted sample; data_o_tvalid=0 throughout the gaps.
- Reset mid-block: 100,100, then reset for 1 cycle, then 8,8,8,8 -> outputs 0/0 during and after reset; exactly one pulse, value 8, with no contribution from the 100s.
- Back-to-back blocks: 1..8 continuous -> pulses of 2 then 6 exactly 4 cycles apart. With LOG2_N=0, the input 5,-3 -> output 5,-3, each one cycle later with matching valid.

Source files
------------

// File: rtl/stream_averager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_averager : block-averaging decimator, one mean per 2^LOG2_N samples
// Revision 1.0
// ---------------------------------------------------------------------------
module stream_averager #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i_tdata,
  input  logic                  data_i_tvalid,
  output logic [DATA_WIDTH-1:0] data_o_tdata,
  output logic                  data_o_tvalid
);

  generate
    if (LOG2_N == 0) begin : g_register
      always_ff @(posedge clk) begin
        if (reset) begin
          data_o_tdata  <= '0;
          data_o_tvalid <= 1'b0;
        end else begin
          data_o_tvalid <= data_i_tvalid;
          if (data_i_tvalid) begin
            data_o_tdata <= data_i_tdata;
          end
        end
      end
    end else begin : g_block
      localparam int ACC_W = DATA_WIDTH + LOG2_N;

      logic        [LOG2_N-1:0]     cnt;
      logic signed [ACC_W-1:0]      acc;
      logic signed [DATA_WIDTH-1:0] sample;
      logic signed [ACC_W-1:0]      acc_sum;
      logic signed [DATA_WIDTH-1:0] mean;
      logic                         last;

      // Guard bits make acc_sum exact; the shifted mean always fits DATA_WIDTH.
      assign sample  = data_i_tdata;
      assign acc_sum = acc + ACC_W'(sample);
      assign mean    = DATA_WIDTH'(acc_sum >>> LOG2_N);
      assign last    = &cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt           <= '0;
          acc           <= '0;
          data_o_tdata  <= '0;
          data_o_tvalid <= 1'b0;
        end else begin
          data_o_tvalid <= 1'b0;
          if (data_i_tvalid) begin
            if (last) begin
              data_o_tdata  <= mean;
              data_o_tvalid <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
            end else begin
              acc <= acc_sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
